// File: rtl/mips_lsu.sv
// Load/store unit in front of the mem_harvard data port: alignment check, lane steering,
// stall handshake and load extension. Optional access timeout under `LSU_TIMEOUT_EN`.
module mips_lsu #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dp_address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        read_dp,
    output logic        write_dp,
    input  logic [31:0] dp_data,
    input  logic        stall
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpSb  = 4'd8;
    localparam logic [3:0] OpSh  = 4'd9;
    localparam logic [3:0] OpSw  = 4'd10;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_TIMEOUT - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] dp_address_q, dp_address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        read_dp_q, read_dp_d;
    logic        write_dp_q, write_dp_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        req_legal;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic [31:0] lane;
    logic [31:0] load_data;

    // Request decode: lane mask, replicated store data and alignment.
    always_comb begin
        req_legal      = 1'b1;
        req_misaligned = 1'b0;
        req_be         = 4'b0000;
        req_wd         = 32'h0;
        case (req_op)
            OpLb, OpLbu: req_be = 4'b0001 << req_addr[1:0];
            OpLh, OpLhu: begin
                req_be         = 4'b0011 << req_addr[1:0];
                req_misaligned = req_addr[0];
            end
            OpLw: begin
                req_be         = 4'b1111;
                req_misaligned = |req_addr[1:0];
            end
            OpSb: begin
                req_be = 4'b0001 << req_addr[1:0];
                req_wd = {4{req_wdata[7:0]}};
            end
            OpSh: begin
                req_be         = 4'b0011 << req_addr[1:0];
                req_wd         = {2{req_wdata[15:0]}};
                req_misaligned = req_addr[0];
            end
            OpSw: begin
                req_be         = 4'b1111;
                req_wd         = req_wdata;
                req_misaligned = |req_addr[1:0];
            end
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin
        lane = dp_data >> {off_q, 3'b000};
        case (op_q)
            OpLb:    load_data = {{24{lane[7]}}, lane[7:0]};
            OpLbu:   load_data = {24'h0, lane[7:0]};
            OpLh:    load_data = {{16{lane[15]}}, lane[15:0]};
            OpLhu:   load_data = {16'h0, lane[15:0]};
            OpLw:    load_data = dp_data;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        dp_address_d = dp_address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        read_dp_d    = read_dp_q;
        write_dp_d   = write_dp_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d  = req_op;
                    off_d = req_addr[1:0];
                    if (!req_legal || req_misaligned) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d      = StAccess;
                        dp_address_d = {req_addr[31:2], 2'b00};
                        byteenable_d = req_be;
                        writedata_d  = req_wd;
                        read_dp_d    = ~req_op[3];
                        write_dp_d   = req_op[3];
`ifdef LSU_TIMEOUT_EN
                        cnt_d        = '0;
`endif
                    end
                end
            end
            StAccess: begin
                if (!stall) begin
                    state_d      = StResp;
                    read_dp_d    = 1'b0;
                    write_dp_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_data;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    // Abort: an in-flight store may or may not have landed.
                    state_d      = StResp;
                    read_dp_d    = 1'b0;
                    write_dp_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            op_q         <= 4'h0;
            off_q        <= 2'b00;
            dp_address_q <= 32'h0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'b0000;
            read_dp_q    <= 1'b0;
            write_dp_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            dp_address_q <= dp_address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            read_dp_q    <= read_dp_d;
            write_dp_q   <= write_dp_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready  = rst && (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dp_address = dp_address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign read_dp    = read_dp_q;
    assign write_dp   = write_dp_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: a byte-level golden memory predicts every response, a word memory
// plays mem_harvard, and one negedge process compares all outputs each cycle.
module tb_mips_lsu;

    localparam int To = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dp_address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read_dp;
    logic        write_dp;
    logic [31:0] dp_data;
    logic        stall = 1'b0;

    mips_lsu #(.WAIT_TIMEOUT(To)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dp_address (dp_address),
        .writedata  (writedata),
        .byteenable (byteenable),
        .read_dp    (read_dp),
        .write_dp   (write_dp),
        .dp_data    (dp_data),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // mem_harvard stand-in; returns junk while stalled.
    logic [31:0] mem [0:255];
    assign dp_data = stall ? 32'hDEADBEEF : mem[dp_address[9:2]];
    always @(posedge clk) begin
        if (write_dp && !stall) begin
            for (int j = 0; j < 4; j++)
                if (byteenable[j]) mem[dp_address[9:2]][8*j +: 8] <= writedata[8*j +: 8];
        end
    end

    logic [7:0] gold [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit          chk_en = 1'b0;
    logic        exp_ready = 1'b0, exp_rv = 1'b0, exp_err = 1'b0;
    logic        exp_rd = 1'b0, exp_wr = 1'b0, exp_dpchk = 1'b0;
    logic [31:0] exp_rdata = 32'h0, exp_addr = 32'h0, exp_wd = 32'h0;
    logic [3:0]  exp_be = 4'h0;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
            cmp("resp_valid", {31'h0, resp_valid}, {31'h0, exp_rv});
            cmp("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
            cmp("resp_rdata", resp_rdata, exp_rdata);
            cmp("read_dp", {31'h0, read_dp}, {31'h0, exp_rd});
            cmp("write_dp", {31'h0, write_dp}, {31'h0, exp_wr});
            if (exp_dpchk) begin
                cmp("dp_address", dp_address, exp_addr);
                cmp("byteenable", {28'h0, byteenable}, {28'h0, exp_be});
                cmp("writedata", writedata, exp_wd);
            end
        end
    end

    // Issues one request from IDLE and walks it to completion, setting expectations per cycle.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int nstall, input logic [31:0] lit_rd, input logic [3:0] lit_be);
        int size, off, k;
        bit sgn, legal, mis, store, aborted;
        logic [3:0]  be, got_be;
        logic [31:0] wexp, rexp, got_rd;
        legal = 1'b1; sgn = 1'b0; size = 1;
        case (op)
            4'd0:  begin size = 1; sgn = 1'b1; end
            4'd1:  size = 1;
            4'd2:  begin size = 2; sgn = 1'b1; end
            4'd3:  size = 2;
            4'd4:  size = 4;
            4'd8:  size = 1;
            4'd9:  size = 2;
            4'd10: size = 4;
            default: legal = 1'b0;
        endcase
        store = op[3];
        off = int'(addr[1:0]);
        mis = legal && ((off % size) != 0);
        be = 4'h0; wexp = 32'h0; rexp = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (j >= off && j < off + size) be[j] = 1'b1;
            if (store) wexp[8*j +: 8] = wd[8*(j % size) +: 8];
        end
        if (!store) begin
            for (int i = 0; i < size; i++) rexp[8*i +: 8] = gold[(int'(addr[9:0]) + i) % 1024];
            if (sgn && rexp[8*size-1])
                for (int i = size; i < 4; i++) rexp[8*i +: 8] = 8'hFF;
        end

        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; stall = 1'b0;
        @(posedge clk); #1;
        // Junk on the request bus must be ignored until IDLE again.
        req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        exp_ready = 1'b0;
        if (!legal || mis) begin
            exp_rv = 1'b1; exp_err = 1'b1; exp_rdata = 32'h0;
            got_rd = resp_rdata;
        end else begin
            exp_rd = !store; exp_wr = store; exp_dpchk = 1'b1;
            exp_addr = {addr[31:2], 2'b00}; exp_be = be; exp_wd = wexp;
            got_be = byteenable;
            aborted = 1'b0; k = 0;
            while (k < nstall && !aborted) begin
                stall = 1'b1;
                @(posedge clk); #1;
                k++;
                if (ToEn && k == To) aborted = 1'b1;
            end
            if (!aborted) begin
                stall = 1'b0;
                @(posedge clk); #1;
            end
            stall = 1'b0;
            exp_rd = 1'b0; exp_wr = 1'b0; exp_dpchk = 1'b0; exp_rv = 1'b1;
            if (aborted) begin
                exp_err = 1'b1; exp_rdata = 32'h0;
            end else begin
                exp_err = 1'b0; exp_rdata = rexp;
                if (store)
                    for (int i = 0; i < size; i++)
                        gold[(int'(addr[9:0]) + i) % 1024] = wd[8*i +: 8];
            end
            got_rd = resp_rdata;
            cmp("lit_byteenable", {28'h0, got_be}, {28'h0, lit_be});
        end
        cmp("lit_rdata", got_rd, lit_rd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_rv = 1'b0; exp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) gold[i] = 8'h0;
        mem[64] = 32'h8001FF7F;
        gold[256] = 8'h7F; gold[257] = 8'hFF; gold[258] = 8'h01; gold[259] = 8'h80;

        // Power-up reset: everything zero, not ready.
        @(posedge clk); #1;
        exp_dpchk = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; exp_ready = 1'b1;
        @(posedge clk); #1;
        exp_dpchk = 1'b0;

        // Loads from 0x100 = 0x8001FF7F.
        do_req(4'd0, 32'h100, 32'h0, 0, 32'h0000007F, 4'b0001);
        do_req(4'd0, 32'h101, 32'h0, 0, 32'hFFFFFFFF, 4'b0010);
        do_req(4'd1, 32'h103, 32'h0, 0, 32'h00000080, 4'b1000);
        do_req(4'd2, 32'h102, 32'h0, 0, 32'hFFFF8001, 4'b1100);
        do_req(4'd3, 32'h100, 32'h0, 0, 32'h0000FF7F, 4'b0011);
        do_req(4'd4, 32'h100, 32'h0, 0, 32'h8001FF7F, 4'b1111);

        // Stores and read-back merge.
        do_req(4'd8, 32'h203, 32'h000000AB, 0, 32'h0, 4'b1000);
        do_req(4'd9, 32'h202, 32'h00001234, 0, 32'h0, 4'b1100);
        do_req(4'd8, 32'h200, 32'hFFFFFF55, 0, 32'h0, 4'b0001);
        do_req(4'd4, 32'h200, 32'h0, 0, 32'h12340055, 4'b1111);
        do_req(4'd10, 32'h204, 32'hCAFEF00D, 0, 32'h0, 4'b1111);
        do_req(4'd1, 32'h206, 32'h0, 0, 32'h000000FE, 4'b0100);

        // Stalled load.
        do_req(4'd4, 32'h100, 32'h0, 5, ToEn ? 32'h0 : 32'h8001FF7F, 4'b1111);

        // Errors: misaligned word, misaligned half store, illegal op.
        do_req(4'd4, 32'h102, 32'h0, 0, 32'h0, 4'b0000);
        do_req(4'd9, 32'h301, 32'h5555, 0, 32'h0, 4'b0000);
        do_req(4'd7, 32'h100, 32'h0, 0, 32'h0, 4'b0000);
        do_req(4'd4, 32'h100, 32'h0, 0, 32'h8001FF7F, 4'b1111);

        // Long stall: aborts with the timeout, otherwise still waiting after 50 cycles.
        do_req(4'd4, 32'h100, 32'h0, 50, ToEn ? 32'h0 : 32'h8001FF7F, 4'b1111);

        // Reset in the middle of a stalled access.
        req_valid = 1'b1; req_op = 4'd4; req_addr = 32'h100; stall = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; stall = 1'b1;
        exp_ready = 1'b0; exp_rd = 1'b1; exp_dpchk = 1'b1;
        exp_addr = 32'h100; exp_be = 4'b1111; exp_wd = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_rd = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_rdata = 32'h0; exp_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; exp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        stall = 1'b0; exp_dpchk = 1'b0;
        do_req(4'd0, 32'h103, 32'h0, 0, 32'hFFFFFF80, 4'b1000);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Load/store unit sitting directly upstream of the data port of mem_harvard. It accepts one CPU memory request at a time (byte/half/word, signed/unsigned loads), checks alignment, and generates the word-aligned dp_address, byteenable and lane-replicated writedata. It holds the request while mem_harvard asserts stall, then extracts and extends the returned lane into a 32-bit response for the CPU writeback stage.

Parameters:
WAIT_TIMEOUT, 255, stall cycles tolerated in ACCESS before abort (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  LSU can accept; 1 only in IDLE with rst high
req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 8 SB, 9 SH, 10 SW; others illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits significant for SB/SH
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal op or timeout; qualified by resp_valid
dp_address  out  32  word-aligned address to mem_harvard
writedata  out  32  store data to mem_harvard
byteenable  out  4  active lanes
read_dp  out  1  read strobe
write_dp  out  1  write strobe
dp_data  in  32  read data from mem_harvard, valid in any cycle where stall=0
stall  in  1  mem_harvard not ready; access completes at the first rising edge with read_dp|write_dp and stall=0

Behaviour:
- Lane order: byte at offset k = addr[1:0] occupies bits [8k+7:8k] of dp_data/writedata.
- Reset (rst=0 at rising edge): state IDLE. resp_valid, resp_err, read_dp and write_dp = 0. resp_rdata, dp_address, writedata and byteenable = 0. req_ready = 0 while rst=0.
- Reset mid-access: the transaction is abandoned. Strobes are 0 after that edge, no response is issued and no partial write is retried.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, the request is registered:
  - Illegal op, or misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESP with err=1. No memory strobe is ever raised.
  - Otherwise go to ACCESS.
- ACCESS: drive outputs from registered values only (stable while stall=1):
  - dp_address = {addr[31:2],2'b00}.
  - byteenable: B = 4'b0001<<off; H = 4'b0011<<off; W = 4'b1111.
  - writedata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
  - Loads drive writedata = 0.
  - read_dp=1 for loads; write_dp=1 for stores. Never both.
  - On an edge with stall=0: capture the extracted data and go to RESP. Strobes drop to 0 on that same edge.
- Extraction: LB/LBU take dp_data[8*off+:8], sign/zero-extended. LH/LHU take dp_data[8*off+:16], sign/zero-extended. LW takes dp_data unchanged.
- RESP: resp_valid=1 for exactly one cycle, carrying resp_rdata/resp_err, then IDLE. resp_rdata and resp_err hold their values until the next response. req_ready=0 in RESP (no back-to-back overlap).
- Latency, valid access: accept edge N, strobes high in cycle N+1. With no stall, resp_valid is high in cycle N+2; each stall cycle adds 1.
- Latency, error: resp_valid is high in cycle N+1.
- req_* inputs are ignored outside IDLE.
- stall outside ACCESS is ignored.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to ACCESS and increments on each edge with stall=1. When it reaches WAIT_TIMEOUT, strobes drop and the FSM goes to RESP with resp_err=1 and resp_rdata=0. A store aborted this way is not guaranteed unwritten.
- Undefined: no counter; ACCESS waits indefinitely and WAIT_TIMEOUT is unused.

Test Plan:
- Reset: hold rst=0 for 2 edges during ACCESS with stall=1 -> read_dp=write_dp=resp_valid=0, req_ready=0; after release, req_ready=1 and no response ever appears.
- Loads: memory word 0x8001FF7F at 0x100. Results:
  - LB 0x100 -> 0x0000007F
  - LB 0x101 -> 0xFFFFFFFF
  - LBU 0x103 -> 0x00000080
  - LH 0x102 -> 0xFFFF8001
  - LHU 0x100 -> 0x0000FF7F
  - LW 0x100 -> 0x8001FF7F
  - byteenable values 0001/0010/1000/1100/0011/1111 respectively
  - each resp_valid 2 cycles after accept
- Stores: SB 0x203 wdata 0x000000AB -> dp_address 0x200, byteenable 1000, writedata 0xABABABAB. SH 0x202 wdata 0x1234 -> byteenable 1100, writedata 0x12341234. Read-back LW 0x200 confirms merge.
- Stall: LW with stall held 5 cycles -> dp_address/read_dp stable throughout, resp_valid exactly 7 cycles after accept, single pulse.
- Errors: LW 0x102, SH 0x301 and op 7 -> resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0, read_dp/write_dp never asserted.
- Timeout (LSU_TIMEOUT_EN, WAIT_TIMEOUT=4): stall held high -> read_dp drops after 4 stall edges, resp_err=1. Without the macro, the same stimulus is still waiting after 50 cycles.
